// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 unified-memory arbiter.
package rv32_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] D_SIZE_B = 2'b00;
  localparam logic [1:0] D_SIZE_H = 2'b01;
  localparam logic [1:0] D_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    ERR   = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  // Byte-lane placement of a data store.
  typedef struct packed {
    logic              misalign;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } store_lane_t;

endpackage

// File: rtl/rv32_store_align.sv
// Maps a right-justified store onto memory byte lanes and flags bad alignment.
module rv32_store_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  output store_lane_t       lane_o
);

  // Lane steering and alignment check per access size.
  always_comb begin
    lane_o = '0;
    case (size_i)
      D_SIZE_B: begin
        lane_o.be    = 4'b0001 << addr_lo_i;
        lane_o.wdata = {4{wdata_i[7:0]}};
      end
      D_SIZE_H: begin
        lane_o.be       = addr_lo_i[1] ? 4'hC : 4'h3;
        lane_o.wdata    = {2{wdata_i[15:0]}};
        lane_o.misalign = addr_lo_i[0];
      end
      D_SIZE_W: begin
        lane_o.be       = 4'hF;
        lane_o.wdata    = wdata_i;
        lane_o.misalign = |addr_lo_i;
      end
      default: lane_o.misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins by default; a loss counter forces a fetch grant to avoid starvation.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_valid_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rvalid_q, d_rvalid_q, d_err_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic        idle_c, force_if_c, grant_if_c, grant_d_c;
  store_lane_t d_lane;

  rv32_store_align u_store_align (
    .size_i    (d_size_i),
    .addr_lo_i (d_addr_i[1:0]),
    .wdata_i   (d_wdata_i),
    .lane_o    (d_lane)
  );

  // Winner selection, only while idle.
  assign idle_c     = (state_q == IDLE);
  assign force_if_c = (starve_q == CNT_W'(MAX_WAIT));
  assign grant_if_c = idle_c && if_valid_i && (force_if_c || !d_valid_i);
  assign grant_d_c  = idle_c && d_valid_i && !(force_if_c && if_valid_i);

  // Consecutive fetch-loss counter, saturating at the forcing threshold.
  always_comb begin
    starve_d = starve_q;
    if (grant_if_c) begin
      starve_d = '0;
    end else if (grant_d_c && if_valid_i && (starve_q < CNT_W'(MAX_WAIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Transaction FSM with request latches and registered responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_IF;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      mem_req_q   <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      starve_q    <= starve_d;
      case (state_q)
        IDLE: begin
          if (grant_d_c) begin
            owner_q     <= OWNER_D;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i & ~ADDR_W'(3);
            mem_be_q    <= d_we_i ? d_lane.be : 4'hF;
            mem_wdata_q <= d_we_i ? d_lane.wdata : '0;
            if (d_lane.misalign) begin
              state_q <= ERR;
            end else begin
              state_q   <= ISSUE;
              mem_req_q <= 1'b1;
            end
          end else if (grant_if_c) begin
            owner_q     <= OWNER_IF;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i & ~ADDR_W'(3);
            mem_be_q    <= 4'hF;
            mem_wdata_q <= '0;
            state_q     <= ISSUE;
            mem_req_q   <= 1'b1;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
            if (owner_q == OWNER_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata_i;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_we_q ? '0 : mem_rdata_i;
            end
          end
        end
        ERR: begin
          state_q    <= IDLE;
          d_rvalid_q <= 1'b1;
          d_err_q    <= 1'b1;
          d_rdata_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ready_o  = grant_if_c;
  assign d_ready_o   = grant_d_c;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_err_o     = d_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench for rv32_mem_arbiter: memory responder plus reference memory model.
module tb_rv32_mem_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ready_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_valid_i = 1'b0, d_we_i = 1'b0;
  logic [1:0]  d_size_i = '0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic        d_ready_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  rv32_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_valid_i(if_valid_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_valid_i(d_valid_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_ready_o(d_ready_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Stimulus-side knobs (written only by the main initial block).
  int lat_cfg = 1;
  int stray_req = 0;
  logic [31:0] ref_mem [int unsigned];

  // Responder-side state (written only by the responder).
  logic [31:0] mem_arr [int unsigned];
  int stray_done = 0;
  bit pend = 1'b0;
  int cnt = 0;
  int req_cnt = 0;
  int overlap_cnt = 0;
  logic [31:0] rd_pend = '0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_we = 1'b0;

  // Initial memory image; word 4 (byte 0x10) holds a known fetch word.
  function automatic logic [31:0] dflt(input int unsigned idx);
    if (idx == 4) return 32'hDEADBEEF;
    return (32'(idx) * 32'h9E3779B9) ^ 32'h13579BDF;
  endfunction

  function automatic logic [31:0] arr_rd(input int unsigned idx);
    return mem_arr.exists(idx) ? mem_arr[idx] : dflt(idx);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : dflt(idx);
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] lo);
    if (size == 2'd0) return 4'(4'd1 << lo);
    if (size == 2'd1) return 4'(4'd3 << lo);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return 32'(wd[7:0]) * 32'h01010101;
    if (size == 2'd1) return 32'(wd[15:0]) * 32'h00010001;
    return wd;
  endfunction

  // Memory model: accepts mem_req, answers lat_cfg cycles later, can inject a stray strobe.
  always @(negedge clk_i) begin
    logic [31:0] w;
    int unsigned widx;
    mem_rvalid_i = 1'b0;
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd_pend;
        pend = 1'b0;
      end
    end
    if (stray_done != stray_req) begin
      stray_done   = stray_req;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0BAD0;
    end
    if (mem_req_o === 1'b1) begin
      if (pend) overlap_cnt++;
      req_cnt++;
      cap_addr  = mem_addr_o;
      cap_we    = mem_we_o;
      cap_be    = mem_be_o;
      cap_wdata = mem_wdata_o;
      widx      = 32'(mem_addr_o >> 2);
      rd_pend   = arr_rd(widx);
      if (mem_we_o) begin
        w = arr_rd(widx);
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem_arr[widx] = w;
      end
      pend = 1'b1;
      cnt  = lat_cfg;
    end
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({if_ready_o, if_rvalid_o, if_rdata_o, d_ready_o, d_rvalid_o, d_rdata_o, d_err_o,
                 mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o});
  endfunction

  // One isolated request, checked for grant, timing, memory fields and response.
  task automatic run_single(input string tag, input bit is_d, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    int unsigned widx = 32'(addr >> 2);
    logic [31:0] exp_word = ref_rd(widx);
    bit exp_err = is_d && ((size == 2'd3) || ((addr % (32'd1 << size)) != 0));
    bit is_st = is_d && we;
    logic [3:0]  ebe = ref_be(size, addr[1:0]);
    logic [31:0] ewd = ref_wd(size, wdata);
    logic [31:0] w, obs_data = '0;
    logic [1:0]  who = '0;
    logic        obs_err = 1'b0;
    int req0 = req_cnt, req_k = 0, rv_k = 0;
    @(negedge clk_i);
    lat_cfg = lat;
    if (is_d) begin
      d_valid_i = 1'b1; d_we_i = we; d_size_i = size; d_addr_i = addr; d_wdata_i = wdata;
    end else begin
      if_valid_i = 1'b1; if_addr_i = addr;
    end
    #1;
    chk({tag, "_ready"}, is_d ? d_ready_o : if_ready_o, 1);
    for (int k = 1; k <= 40 && rv_k == 0; k++) begin
      @(negedge clk_i);
      if (k == 1) begin if_valid_i = 1'b0; d_valid_i = 1'b0; end
      #1;
      if (mem_req_o && req_k == 0) req_k = k;
      if (if_rvalid_o || d_rvalid_o) begin
        rv_k = k; who = {if_rvalid_o, d_rvalid_o};
        obs_data = is_d ? d_rdata_o : if_rdata_o; obs_err = d_err_o;
      end
    end
    chk({tag, "_lat"}, rv_k, exp_err ? 2 : 2 + lat);
    chk({tag, "_who"}, who, is_d ? 2'b01 : 2'b10);
    chk({tag, "_err"}, obs_err, exp_err);
    chk({tag, "_rdata"}, obs_data, (exp_err || is_st) ? 32'h0 : exp_word);
    chk({tag, "_nreq"}, req_cnt - req0, exp_err ? 0 : 1);
    if (!exp_err) begin
      chk({tag, "_reqk"}, req_k, 1);
      chk({tag, "_addr"}, cap_addr, {addr[31:2], 2'b00});
      chk({tag, "_we"}, cap_we, is_st);
      chk({tag, "_be"}, cap_be, is_st ? ebe : 4'hF);
      if (is_st) begin
        chk({tag, "_wdata"}, cap_wdata, ewd);
        w = exp_word;
        for (int b = 0; b < 4; b++) if (ebe[b]) w[8*b +: 8] = ewd[8*b +: 8];
        ref_mem[widx] = w;
      end
    end
  endtask

  initial begin
    int ng, losses, strobes, rvk;
    logic [31:0] exp_d, exp_i;

    // Reset state
    repeat (3) @(negedge clk_i);
    #1 chk("reset_outs", all_outs(), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fetch-only with single-cycle memory
    run_single("if_only", 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 1);
    chk("if_only_word", if_rdata_o, 32'hDEADBEEF);

    // Contention: both requesters held high
    @(negedge clk_i);
    lat_cfg = 1;
    if_valid_i = 1'b1; if_addr_i = 32'h20;
    d_valid_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_addr_i = 32'h104;
    ng = 0; losses = 0;
    for (int c = 0; c < 80 && ng < 11; c++) begin
      if (c > 0) @(negedge clk_i);
      #1;
      if (if_ready_o || d_ready_o) begin
        if (losses == MAX_WAIT) begin
          chk($sformatf("cont_grant%0d", ng), {if_ready_o, d_ready_o}, 2'b10);
          losses = 0;
        end else begin
          chk($sformatf("cont_grant%0d", ng), {if_ready_o, d_ready_o}, 2'b01);
          losses++;
        end
        ng++;
      end
    end
    chk("cont_count", ng, 11);
    @(negedge clk_i);
    if_valid_i = 1'b0; d_valid_i = 1'b0;
    repeat (6) @(negedge clk_i);

    // Lane-aligned stores, then read back
    run_single("sb", 1'b1, 1'b1, 2'd0, 32'h103, 32'h000000AB, 1);
    run_single("sh", 1'b1, 1'b1, 2'd1, 32'h102, 32'h00001234, 2);
    run_single("sw", 1'b1, 1'b1, 2'd2, 32'h108, 32'hCAFEF00D, 1);
    run_single("lw_back", 1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1);

    // Misaligned / illegal-size requests
    run_single("mis_sh", 1'b1, 1'b1, 2'd1, 32'h101, 32'h5555, 1);
    run_single("mis_sw", 1'b1, 1'b1, 2'd2, 32'h102, 32'h6666, 1);
    run_single("mis_sz", 1'b1, 1'b0, 2'd3, 32'h100, 32'h0, 1);

    // Long latency with a fetch waiting, back-to-back grant in the response cycle
    exp_d = ref_rd(32'h108 >> 2);
    exp_i = ref_rd(32'h30 >> 2);
    @(negedge clk_i);
    lat_cfg = 5;
    d_valid_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_addr_i = 32'h108;
    #1 chk("b2b_dready", d_ready_o, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk_i);
      if (k == 1) begin d_valid_i = 1'b0; if_valid_i = 1'b1; if_addr_i = 32'h30; end
      #1;
      chk($sformatf("b2b_k%0d", k), {if_ready_o, d_rvalid_o}, (k == 7) ? 2'b11 : 2'b00);
      if (k == 7) chk("b2b_drdata", d_rdata_o, exp_d);
    end
    rvk = 0;
    for (int k = 8; k <= 40 && rvk == 0; k++) begin
      @(negedge clk_i);
      if (k == 8) if_valid_i = 1'b0;
      #1;
      if (if_rvalid_o) begin rvk = k; chk("b2b_irdata", if_rdata_o, exp_i); end
    end
    chk("b2b_ilat", rvk, 14);

    // Stray memory strobe while idle
    @(negedge clk_i);
    stray_req++;
    strobes = 0;
    repeat (5) begin
      @(negedge clk_i);
      #1 strobes += int'(if_rvalid_o) + int'(d_rvalid_o) + int'(mem_req_o);
    end
    chk("stray_quiet", strobes, 0);
    run_single("after_stray", 1'b1, 1'b0, 2'd2, 32'h104, 32'h0, 2);

    // Reset in the middle of a transaction
    @(negedge clk_i);
    lat_cfg = 4;
    d_valid_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'd2; d_addr_i = 32'h10C;
    #1 chk("rst_dready", d_ready_o, 1);
    @(negedge clk_i);
    d_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0;
    #1 chk("rst_mid_outs", all_outs(), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    strobes = 0;
    repeat (10) begin
      @(negedge clk_i);
      #1 strobes += int'(if_rvalid_o) + int'(d_rvalid_o) + int'(mem_req_o);
    end
    chk("rst_no_late", strobes, 0);
    run_single("after_rst", 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 3);

    // Randomized single transactions
    for (int i = 0; i < 24; i++) begin
      bit is_d = ($urandom_range(2) != 0);
      run_single($sformatf("rnd%0d", i), is_d, 1'($urandom), 2'($urandom),
                 32'h100 + 32'($urandom_range(31)), $urandom, 1 + $urandom_range(3));
    end

    chk("no_overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
